spi_slave_if: RTL and testbench
===============================

# spi_slave_if

SPI slave front-end that sits directly upstream of the single-port SPI RAM. It deserialises MOSI frames into the 10-bit command/data word the RAM consumes (`rx_data`, `rx_valid`) and serialises the RAM's read response (`tx_data`, `tx_valid`) back out on MISO. The SPI bit clock is the system clock `clk`. Chip select is `ss_n`.

## Interface
- `WORD_W`, 10: width of the word delivered to the RAM (2 control bits plus 8 payload bits).
- `DATA_W`, 8: width of the RAM read data serialised on MISO.
- `clk` input 1: system clock; MOSI is sampled and MISO is driven on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ss_n` input 1: chip select, active low.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first.
- `rx_data` output `WORD_W`: assembled word to the RAM. Bits [9:8] are control: `WR_ADDR`=00, `WR_DATA`=01, `RD_ADDR`=10, `RD_DATA`=11.
- `rx_valid` output 1: one-cycle pulse; `rx_data` is valid while it is high.
- `tx_data` input `DATA_W`: read data from the RAM.
- `tx_valid` input 1: RAM read data valid.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE -> CHK_CMD when `ss_n`=0.
- In CHK_CMD, the first `mosi` bit is captured as `rx_data[9]`:
  - `mosi`=0 -> WRITE.
  - `mosi`=1 and `rd_addr_done`=0 -> READ_ADD.
  - `mosi`=1 and `rd_addr_done`=1 -> READ_DATA.
- WRITE, READ_ADD and READ_DATA each shift in 9 further bits (`rx_data[8:0]`, MSB first) under a 4-bit counter.
- After the 10th bit:
  - Pulse `rx_valid` for one cycle; `rx_data` holds the word unchanged.
  - Ignore further `mosi` until `ss_n` rises.
- `rd_addr_done` flag:
  - Set when a READ_ADD word is delivered.
  - Cleared when a READ_DATA word is delivered.
  - Unaffected by WRITE.
  - Word content is passed through unchanged regardless of the flag.
- READ_DATA response:
  - After its `rx_valid` pulse, wait for `tx_valid`.
  - Latch `tx_data` into the output shift register.
  - Drive `miso` with bits 7..0, one per cycle.
  - Then drive `miso` = 0 and hold until `ss_n` rises.
- `tx_valid` outside the READ_DATA wait window is ignored.
- Any state -> IDLE when `ss_n`=1. This aborts the frame:
  - Counters cleared.
  - No `rx_valid` for a partial word.
  - `miso` forced to 0.
  - `rd_addr_done` unchanged.

## Timing
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, `miso`=0, `rd_addr_done`=0, counters 0.
- Assertion of `rst` clears all of the above immediately, including mid-frame or mid-MISO shift.
- `ss_n` sampled low at edge k -> CHK_CMD from k+1. `mosi` is sampled at edges k+1 .. k+10.
- `rx_valid` is high during cycle k+11 only.
- RAM responds with `tx_valid` one cycle after the RD_DATA `rx_valid`. At the edge where `tx_valid`=1, `miso` becomes bit 7; bits 6..0 follow on the next 7 edges.
- End-of-frame boundaries:
  - `ss_n` rising at edge k+10, the edge that samples the 10th bit: still delivers the word; `rx_valid` pulses at k+11.
  - `ss_n` rising at edge k+9 or earlier: no delivery.
  - `ss_n` high during MISO shift: truncates output; `miso`=0 on the next cycle.
- `rx_valid` never pulses twice per frame. Back-to-back frames require at least one cycle of `ss_n`=1.

## Structure
- Shared package `spi_pkg` holds:
  - The control-bit enum (`WR_ADDR`, `WR_DATA`, `RD_ADDR`, `RD_DATA`).
  - The FSM state enum.
  - The `WORD_W`/`DATA_W` constants used by the slave and the RAM.
- One natural sub-module: `spi_shift_out`, the 8-bit parallel-load MISO shifter with load and shift-enable.

## Test plan
- Reset mid-frame:
  - Stimulus: `rst`=1 after 5 bits.
  - Required: `rx_valid`=0 and `miso`=0 immediately. With `ss_n` still low after release, the next frame starts in IDLE -> CHK_CMD and delivers normally.
- Write sequence:
  - Stimulus: frame 00_1010_0101.
  - Required: `rx_data`=0x0A5 with one-cycle `rx_valid` at k+11.
  - Stimulus: frame 01_1111_0000.
  - Required: `rx_data`=0x1F0.
- Read sequence:
  - Stimulus: frame 10_0000_0011.
  - Required: `rx_data`=0x203 and `rd_addr_done`=1.
  - Stimulus: frame 11_xxxx_xxxx with the RAM returning `tx_data`=0xC3.
  - Required: `miso` = 1,1,0,0,0,0,1,1 on consecutive cycles and `rd_addr_done`=0.
- Abort:
  - Stimulus: `ss_n` rises after 6 bits.
  - Required: no `rx_valid`; IDLE next cycle; a following full frame delivers the correct word.
- Boundary:
  - Stimulus: `ss_n` rises on the edge sampling the 10th bit.
  - Required: word delivered.
  - Stimulus: same, one edge earlier.
  - Required: no delivery.
- Spurious `tx_valid`:
  - Stimulus: `tx_valid` pulses during a WRITE frame.
  - Required: `miso` stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end and the single-port SPI RAM.
// Holds word widths, the control-bit encoding and the slave FSM state type.
package spi_pkg;

  // Word handed to the RAM: 2 control bits followed by 8 payload bits
  localparam int WORD_W = 10;
  // RAM read data returned over MISO
  localparam int DATA_W = 8;

  // Receive counter value at which the last (10th) bit is sampled
  localparam logic [3:0] RX_LAST_CNT = 4'(WORD_W - 2);
  // Transmit counter value at which the final shift (zero fill) happens
  localparam logic [3:0] TX_LAST_CNT = 4'(DATA_W - 1);

  // Control field carried in rx_data[9:8]
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_ctrl_e;

  // Slave FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  // Extract the control field from an assembled word
  function automatic spi_ctrl_e word_ctrl(input logic [WORD_W-1:0] word);
    return spi_ctrl_e'(word[WORD_W-1:WORD_W-2]);
  endfunction

endpackage

// File: rtl/spi_shift_out.sv
// MISO shifter: parallel-loads the RAM read byte, then shifts it out MSB
// first, filling with zeros so the line settles low after the last bit.
module spi_shift_out
  import spi_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_shift_en,
  output logic              o_bit
);

  logic [DATA_W-1:0] r_sreg;

  // Shift register: clear has priority over load, load over shift
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sreg <= {DATA_W{1'b0}};
    end else if (i_clr) begin
      r_sreg <= {DATA_W{1'b0}};
    end else if (i_load) begin
      r_sreg <= i_load_data;
    end else if (i_shift_en) begin
      r_sreg <= {r_sreg[DATA_W-2:0], 1'b0};
    end else begin
      r_sreg <= r_sreg;
    end
  end

  // MISO is taken straight from the register MSB, so it is glitch-free
  assign o_bit = r_sreg[DATA_W-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front-end for the SPI RAM. Deserialises 10-bit MOSI frames into
// rx_data/rx_valid and serialises the RAM read response back out on MISO.
// The SPI bit clock is the system clock; chip select is active low.
module spi_slave_if
  import spi_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic [WORD_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid
);

  spi_state_e        r_state;
  logic [3:0]        r_bit_cnt;      // payload bits received after the command bit
  logic              r_cmd_msb;      // first bit of the frame (rx_data[9])
  logic [WORD_W-3:0] r_rx_shift;     // payload bits 8..1 while the frame is in flight
  logic [WORD_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_word_done;    // word delivered, MOSI ignored until ss_n rises
  logic              r_tx_wait;      // READ_DATA delivered, waiting for RAM read data
  logic              r_tx_busy;      // read byte is being shifted out
  logic [3:0]        r_tx_cnt;
  logic              r_rd_addr_done; // a read address has been sent, next read fetches data

  logic              w_clr;
  logic              w_load;
  logic              w_shift_en;
  logic              w_rx_state;

  // Receiving states share the same shift/deliver behaviour
  assign w_rx_state = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);

  // Main FSM: frame reception, delivery pulse, read-address tracking, MISO sequencing
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_bit_cnt      <= 4'd0;
      r_cmd_msb      <= 1'b0;
      r_rx_shift     <= {(WORD_W-2){1'b0}};
      r_rx_data      <= {WORD_W{1'b0}};
      r_rx_valid     <= 1'b0;
      r_word_done    <= 1'b0;
      r_tx_wait      <= 1'b0;
      r_tx_busy      <= 1'b0;
      r_tx_cnt       <= 4'd0;
      r_rd_addr_done <= 1'b0;
    end else begin
      // rx_valid is a single-cycle pulse unless re-armed below
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bit_cnt   <= 4'd0;
          r_word_done <= 1'b0;
          r_tx_wait   <= 1'b0;
          r_tx_busy   <= 1'b0;
          r_tx_cnt    <= 4'd0;
          if (!i_ss_n) begin
            r_state <= CHK_CMD;
          end else begin
            r_state <= IDLE;
          end
        end

        CHK_CMD: begin
          if (i_ss_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= 4'd0;
          end else begin
            // The first bit picks read vs write; the flag picks address vs data
            r_cmd_msb <= i_mosi;
            r_bit_cnt <= 4'd0;
            if (!i_mosi) begin
              r_state <= WRITE;
            end else if (!r_rd_addr_done) begin
              r_state <= READ_ADD;
            end else begin
              r_state <= READ_DATA;
            end
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (!r_word_done) begin
            if (i_ss_n && (r_bit_cnt != RX_LAST_CNT)) begin
              // Partial word: abort without delivering
              r_state   <= IDLE;
              r_bit_cnt <= 4'd0;
            end else begin
              r_rx_shift <= {r_rx_shift[WORD_W-4:0], i_mosi};
              r_bit_cnt  <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == RX_LAST_CNT) begin
                // Last bit: the word is complete even if ss_n rises on this edge
                r_rx_data   <= {r_cmd_msb, r_rx_shift, i_mosi};
                r_rx_valid  <= 1'b1;
                r_word_done <= 1'b1;
                if (r_state == READ_ADD) begin
                  r_rd_addr_done <= 1'b1;
                end else if (r_state == READ_DATA) begin
                  r_rd_addr_done <= 1'b0;
                end else begin
                  r_rd_addr_done <= r_rd_addr_done;
                end
                if (i_ss_n) begin
                  r_state   <= IDLE;
                  r_tx_wait <= 1'b0;
                end else begin
                  r_tx_wait <= (r_state == READ_DATA);
                end
              end
            end
          end else if (i_ss_n) begin
            // End of frame: any response in progress is truncated
            r_state   <= IDLE;
            r_bit_cnt <= 4'd0;
            r_tx_wait <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= 4'd0;
          end else if (r_tx_wait && i_tx_valid) begin
            r_tx_wait <= 1'b0;
            r_tx_busy <= 1'b1;
            r_tx_cnt  <= 4'd0;
          end else if (r_tx_busy) begin
            if (r_tx_cnt == TX_LAST_CNT) begin
              r_tx_busy <= 1'b0;
            end else begin
              r_tx_cnt <= r_tx_cnt + 4'd1;
            end
          end else begin
            r_tx_busy <= 1'b0;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_bit_cnt <= 4'd0;
          r_tx_wait <= 1'b0;
          r_tx_busy <= 1'b0;
          r_tx_cnt  <= 4'd0;
        end
      endcase
    end
  end

  // MISO shifter control: clear whenever deselected, load on RAM data, then shift
  always_comb begin
    w_clr      = 1'b0;
    w_load     = 1'b0;
    w_shift_en = 1'b0;
    if (i_ss_n) begin
      w_clr = 1'b1;
    end else if (w_rx_state && r_tx_wait && i_tx_valid) begin
      w_load = 1'b1;
    end else if (w_rx_state && r_tx_busy) begin
      w_shift_en = 1'b1;
    end else begin
      w_clr = 1'b0;
    end
  end

  spi_shift_out u_shift_out (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_load      (w_load),
    .i_load_data (i_tx_data),
    .i_shift_en  (w_shift_en),
    .o_bit       (o_miso)
  );

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed, table-driven bench for spi_slave_if. Each record is one frame
// with hand-computed expected word, delivery, read flag and MISO byte.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_tests = 0;
  int n_fail  = 0;

  spi_slave_if dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ss_n     (ss_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rise_at: edge index (after the ss_n-low edge k) at which ss_n is first
  // sampled high; 0 keeps ss_n low for the whole frame window.
  typedef struct {
    logic [9:0] word;
    int         rise_at;
    logic       spur;
    logic       resp;
    logic [7:0] txd;
    logic       exp_valid;
    logic [9:0] exp_data;
    logic       exp_rd_done;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         v_cnt;
    int         v_first;
    int         outside;
    logic [7:0] mv;
    v_cnt   = 0;
    v_first = -1;
    outside = 0;
    mv      = 8'h00;
    ss_n    = 1'b0;
    step(); // edge k
    for (int e = 1; e <= 21; e++) begin
      mosi = (e <= 10) ? v.word[10-e] : 1'b0;
      if (v.rise_at != 0 && e >= v.rise_at) ss_n = 1'b1;
      tx_valid = (v.spur && (e % 3 == 0)) || (v.resp && e == 12);
      tx_data  = v.spur ? 8'hFF : v.txd;
      step();
      if (rx_valid === 1'b1) begin
        v_cnt++;
        if (v_first < 0) v_first = e;
      end
      if (e >= 12 && e <= 19) mv[19-e] = miso;
      else if (miso !== 1'b0) outside++;
      if (v.rise_at != 0 && e == v.rise_at)
        chk(idx, "idle_after_rise", 32'(dut.r_state), 32'(IDLE));
    end
    tx_valid = 1'b0;
    chk(idx, "valid_count", 32'(v_cnt), 32'(v.exp_valid));
    if (v.exp_valid) chk(idx, "valid_cycle", 32'(v_first), 32'd10);
    chk(idx, "rx_data", 32'(rx_data), 32'(v.exp_data));
    chk(idx, "rd_addr_done", 32'(dut.r_rd_addr_done), 32'(v.exp_rd_done));
    chk(idx, "miso_bits", 32'(mv), 32'(v.exp_miso));
    chk(idx, "miso_outside", 32'(outside), 32'd0);
    ss_n = 1'b1;
    step();
    chk(idx, "idle_end", 32'(dut.r_state), 32'(IDLE));
    chk(idx, "miso_end", 32'(miso), 32'd0);
    step();
  endtask

  initial begin
    //           word     rise  spur  resp  txd    valid data    rd    miso
    vecs[0]  = '{10'h0A5, 0,  1'b0, 1'b0, 8'h00, 1'b1, 10'h0A5, 1'b0, 8'h00};
    vecs[1]  = '{10'h1F0, 0,  1'b1, 1'b0, 8'h00, 1'b1, 10'h1F0, 1'b0, 8'h00};
    vecs[2]  = '{10'h203, 0,  1'b0, 1'b0, 8'h00, 1'b1, 10'h203, 1'b1, 8'h00};
    vecs[3]  = '{10'h077, 0,  1'b0, 1'b0, 8'h00, 1'b1, 10'h077, 1'b1, 8'h00};
    vecs[4]  = '{10'h3A5, 0,  1'b0, 1'b1, 8'hC3, 1'b1, 10'h3A5, 1'b0, 8'hC3};
    vecs[5]  = '{10'h155, 7,  1'b0, 1'b0, 8'h00, 1'b0, 10'h3A5, 1'b0, 8'h00};
    vecs[6]  = '{10'h0CC, 0,  1'b0, 1'b0, 8'h00, 1'b1, 10'h0CC, 1'b0, 8'h00};
    vecs[7]  = '{10'h2F1, 10, 1'b0, 1'b0, 8'h00, 1'b1, 10'h2F1, 1'b1, 8'h00};
    vecs[8]  = '{10'h3E7, 9,  1'b0, 1'b0, 8'h00, 1'b0, 10'h2F1, 1'b1, 8'h00};
    vecs[9]  = '{10'h300, 0,  1'b0, 1'b1, 8'h5A, 1'b1, 10'h300, 1'b0, 8'h5A};
    vecs[10] = '{10'h1FF, 0,  1'b0, 1'b1, 8'hA5, 1'b1, 10'h1FF, 1'b0, 8'h00};
    vecs[11] = '{10'h210, 0,  1'b0, 1'b0, 8'h00, 1'b1, 10'h210, 1'b1, 8'h00};
    vecs[12] = '{10'h3FF, 15, 1'b0, 1'b1, 8'hFF, 1'b1, 10'h3FF, 1'b0, 8'hE0};
    vecs[13] = '{10'h2AA, 0,  1'b1, 1'b0, 8'h00, 1'b1, 10'h2AA, 1'b1, 8'h00};

    rst      = 1'b1;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    step();
    step();
    chk(-1, "reset_rx_valid", 32'(rx_valid), 32'd0);
    chk(-1, "reset_rx_data", 32'(rx_data), 32'd0);
    chk(-1, "reset_miso", 32'(miso), 32'd0);
    chk(-1, "reset_state", 32'(dut.r_state), 32'(IDLE));
    chk(-1, "reset_rd_done", 32'(dut.r_rd_addr_done), 32'd0);
    rst = 1'b0;
    step();

    // Reset asserted mid-frame after 5 bits of a read-address word
    ss_n = 1'b0;
    step();
    for (int b = 0; b < 5; b++) begin
      mosi = b[0];
      step();
    end
    chk(-1, "pre_reset_state", 32'(dut.r_state == IDLE), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk(-1, "midreset_rx_valid", 32'(rx_valid), 32'd0);
    chk(-1, "midreset_miso", 32'(miso), 32'd0);
    chk(-1, "midreset_state", 32'(dut.r_state), 32'(IDLE));
    chk(-1, "midreset_bit_cnt", 32'(dut.r_bit_cnt), 32'd0);
    step();
    rst = 1'b0;
    // ss_n stays low: the first table frame starts straight from IDLE

    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
